// File: rtl/gpio_pkg.sv
// gpio_pkg: register map offsets, channel stride and edge polarity encodings for wb_gpio_bank
package gpio_pkg;
  localparam logic [4:0] OFS_OUT      = 5'h00;
  localparam logic [4:0] OFS_OE       = 5'h04;
  localparam logic [4:0] OFS_IN       = 5'h08;
  localparam logic [4:0] OFS_IRQ_EN   = 5'h0C;
  localparam logic [4:0] OFS_IRQ_STAT = 5'h10;
  localparam logic [4:0] OFS_EDGE     = 5'h14;
  localparam logic [4:0] OFS_SET      = 5'h18;
  localparam logic [4:0] OFS_CLR      = 5'h1C;
  localparam int CH_STRIDE = 32'h20;
  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;
  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
endpackage

// File: rtl/gpio_in_cond.sv
// gpio_in_cond: per-channel input synchroniser, optional tick-sampled debounce (GPIO_DEBOUNCE_EN), edge pulses
module gpio_in_cond #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef GPIO_DEBOUNCE_EN
  input  logic             tick,
`endif
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  logic [WIDTH-1:0] s1, s2, prev;
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      prev <= level;
    end
`ifdef GPIO_DEBOUNCE_EN
  logic [WIDTH-1:0] smp;
  // a bit is accepted only when two consecutive tick samples agree
  always_ff @(posedge clk)
    if (rst) begin
      smp <= '0;
      level <= '0;
    end else if (tick) begin
      smp <= s2;
      level <= (~(smp ^ s2) & s2) | ((smp ^ s2) & level);
    end
`else
  assign level = s2;
`endif
  assign rise = level & ~prev;
  assign fall = ~level & prev;
endmodule

// File: rtl/wb_gpio_bank.sv
// wb_gpio_bank: Wishbone multi-channel GPIO with per-bit OE, edge IRQs, SET/CLR writes
// Optional input debounce enabled by defining GPIO_DEBOUNCE_EN.
module wb_gpio_bank
  import gpio_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int WIDTH        = 32,
  parameter int ADDR_W       = 8,
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [ADDR_W-1:0]         wb_adr_i,
  input  logic [3:0]                wb_sel_i,
  input  logic [31:0]               wb_dat_i,
  output logic [31:0]               wb_dat_o,
  output logic                      wb_ack_o,
  output logic [CHANNELS*WIDTH-1:0] gpio_o,
  output logic [CHANNELS*WIDTH-1:0] gpio_oe_o,
  input  logic [CHANNELS*WIDTH-1:0] gpio_i,
  output logic                      irq_o
);
  localparam int CW = ADDR_W - 5;
  logic req;
  logic [CW-1:0] ch;
  logic [4:0] ofs;
  logic [31:0] m, rdata;
  logic [WIDTH-1:0] wm, d;
  logic [31:0] rd [CHANNELS];
  logic [CHANNELS-1:0] irq_v;
  logic unused;
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign ch = wb_adr_i[ADDR_W-1:5];
  assign ofs = {wb_adr_i[4:2], 2'b00};
  assign m = lane_mask(wb_sel_i);
  assign wm = m[WIDTH-1:0];
  assign d = wb_dat_i[WIDTH-1:0] & wm;
  assign unused = ^{wb_adr_i[1:0], wb_dat_i, m} ^ (DEBOUNCE_CYC < 0);
`ifdef GPIO_DEBOUNCE_EN
  logic [31:0] pre;
  logic tick;
  assign tick = pre == 32'(DEBOUNCE_CYC - 1);
  always_ff @(posedge clk) pre <= (rst || tick) ? '0 : pre + 32'd1;
`endif
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] out_r, oe_r, en_r, stat_r, edge_r, lvl, rise, fall;
    logic hit;
    assign hit = req & wb_we_i & (ch == CW'(c));
    gpio_in_cond #(.WIDTH(WIDTH)) u_in (
      .clk(clk),
      .rst(rst),
`ifdef GPIO_DEBOUNCE_EN
      .tick(tick),
`endif
      .pin(gpio_i[c*WIDTH +: WIDTH]),
      .level(lvl),
      .rise(rise),
      .fall(fall)
    );
    // a new edge is OR-ed in after the W1C clear, so a coincident set wins
    always_ff @(posedge clk)
      if (rst) begin
        out_r <= '0;
        oe_r <= '0;
        en_r <= '0;
        stat_r <= '0;
        edge_r <= '0;
      end else begin
        if (hit && ofs == OFS_OUT) out_r <= (out_r & ~wm) | d;
        else if (hit && ofs == OFS_SET) out_r <= out_r | d;
        else if (hit && ofs == OFS_CLR) out_r <= out_r & ~d;
        if (hit && ofs == OFS_OE) oe_r <= (oe_r & ~wm) | d;
        if (hit && ofs == OFS_IRQ_EN) en_r <= (en_r & ~wm) | d;
        if (hit && ofs == OFS_EDGE) edge_r <= (edge_r & ~wm) | d;
        stat_r <= (stat_r & ~((hit && ofs == OFS_IRQ_STAT) ? d : '0)) | (rise & ~edge_r) | (fall & edge_r);
      end
    assign rd[c] = ofs == OFS_OUT      ? 32'(out_r)  :
                   ofs == OFS_OE       ? 32'(oe_r)   :
                   ofs == OFS_IN       ? 32'(lvl)    :
                   ofs == OFS_IRQ_EN   ? 32'(en_r)   :
                   ofs == OFS_IRQ_STAT ? 32'(stat_r) :
                   ofs == OFS_EDGE     ? 32'(edge_r) : '0;
    assign irq_v[c] = |(stat_r & en_r);
    assign gpio_o[c*WIDTH +: WIDTH] = out_r;
    assign gpio_oe_o[c*WIDTH +: WIDTH] = oe_r;
  end
  always_comb begin
    rdata = '0;
    for (int i = 0; i < CHANNELS; i++) rdata = (ch == CW'(i)) ? rd[i] : rdata;
  end
  always_ff @(posedge clk)
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      irq_o <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req & ~wb_we_i) ? rdata : '0;
      irq_o <= |irq_v;
    end
endmodule

// File: tb/tb_wb_gpio_bank.sv
// tb_wb_gpio_bank: randomized scoreboard bench for wb_gpio_bank against a register-level model
module tb_wb_gpio_bank;
`ifdef GPIO_DEBOUNCE_EN
  localparam int SETTLE = 50;
`else
  localparam int SETTLE = 6;
`endif
  logic clk = 0, rst = 1;
  logic cyc = 0, stb = 0, we = 0;
  logic [7:0] adr = 0;
  logic [3:0] sel = 0;
  logic [31:0] dat = 0, dat_o;
  logic ack, irq;
  logic [63:0] gpo, gpoe, gpi = 0;
  int total = 0, passes = 0;
  typedef struct { bit rd; logic [31:0] exp; string nm; } sb_t;
  sb_t sb[$];
  logic [31:0] m_out[2], m_oe[2], m_en[2], m_stat[2], m_edge[2], m_in[2];

  wb_gpio_bank #(.CHANNELS(2), .WIDTH(32), .ADDR_W(8), .DEBOUNCE_CYC(10)) dut (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_dat_i(dat), .wb_dat_o(dat_o), .wb_ack_o(ack), .gpio_o(gpo),
    .gpio_oe_o(gpoe), .gpio_i(gpi), .irq_o(irq)
  );

  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int c;
    c = int'(a[7:5]);
    if (c >= 2) return 0;
    case (a[4:2])
      3'd0: return m_out[c];
      3'd1: return m_oe[c];
      3'd2: return m_in[c];
      3'd3: return m_en[c];
      3'd4: return m_stat[c];
      3'd5: return m_edge[c];
      default: return 0;
    endcase
  endfunction

  function automatic void m_write(input logic [7:0] a, input logic [3:0] s, input logic [31:0] dd);
    int c;
    logic [31:0] mk, dm;
    c = int'(a[7:5]);
    for (int b = 0; b < 4; b++) mk[8*b +: 8] = {8{s[b]}};
    dm = dd & mk;
    if (c >= 2) return;
    case (a[4:2])
      3'd0: m_out[c] = (m_out[c] & ~mk) | dm;
      3'd1: m_oe[c] = (m_oe[c] & ~mk) | dm;
      3'd3: m_en[c] = (m_en[c] & ~mk) | dm;
      3'd4: m_stat[c] = m_stat[c] & ~dm;
      3'd5: m_edge[c] = (m_edge[c] & ~mk) | dm;
      3'd6: m_out[c] = m_out[c] | dm;
      3'd7: m_out[c] = m_out[c] & ~dm;
      default: ;
    endcase
  endfunction

  // settled pin change: each changed bit whose direction matches its EDGE bit latches STAT
  function automatic void m_pins(input logic [31:0] p0, input logic [31:0] p1);
    logic [31:0] np[2];
    np[0] = p0;
    np[1] = p1;
    for (int c = 0; c < 2; c++) begin
      m_stat[c] |= (np[c] & ~m_in[c] & ~m_edge[c]) | (~np[c] & m_in[c] & m_edge[c]);
      m_in[c] = np[c];
    end
  endfunction

  function automatic logic m_irq();
    return |(m_stat[0] & m_en[0]) | |(m_stat[1] & m_en[1]);
  endfunction

  task automatic xfer(input bit w, input logic [7:0] a, input logic [3:0] s, input logic [31:0] dd, input string nm);
    sb_t e;
    e.rd = !w;
    e.exp = m_read(a);
    e.nm = nm;
    sb.push_back(e);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; sel = s; dat = dd;
    @(posedge clk); #1;
    chk({nm, "_ack"}, 64'(ack), 64'd1);
    cyc = 0; stb = 0;
    @(posedge clk); #1;
    chk({nm, "_ack_low"}, 64'(ack), 64'd0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [3:0] s, input logic [31:0] dd, input string nm);
    m_write(a, s, dd);
    xfer(1, a, s, dd, nm);
  endtask

  task automatic rdc(input logic [7:0] a, input string nm);
    xfer(0, a, 4'h0, 32'h0, nm);
  endtask

  task automatic set_pins(input logic [31:0] p0, input logic [31:0] p1);
    m_pins(p0, p1);
    @(posedge clk); #1;
    gpi = {m_in[1], m_in[0]};
    repeat (SETTLE) @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string nm);
    chk({nm, "_gpio_o"}, gpo, {m_out[1], m_out[0]});
    chk({nm, "_gpio_oe"}, gpoe, {m_oe[1], m_oe[0]});
    chk({nm, "_irq"}, 64'(irq), 64'(m_irq()));
  endtask

  always @(negedge clk)
    if (!rst && ack) begin
      if (sb.size() == 0) chk("unexpected_ack", 64'd1, 64'd0);
      else begin
        sb_t e;
        e = sb.pop_front();
        if (e.rd) chk(e.nm, 64'(dat_o), 64'(e.exp));
      end
    end

  initial begin
    for (int c = 0; c < 2; c++) begin
      m_out[c] = 0; m_oe[c] = 0; m_en[c] = 0; m_stat[c] = 0; m_edge[c] = 0; m_in[c] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_dat", 64'(dat_o), 64'd0);
    chk_outs("rst");
    rst = 0;
    rdc(8'h00, "rst_out");
    rdc(8'h04, "rst_oe");
    rdc(8'h10, "rst_stat");

    wr(8'h20, 4'b0011, 32'hA5A5_00FF, "t2_out");
    wr(8'h38, 4'hF, 32'h0000_0F00, "t2_set");
    wr(8'h3C, 4'hF, 32'h0000_0001, "t2_clr");
    chk("t2_ch1", 64'(gpo[63:32]), 64'h0000_0FFE);
    chk_outs("t2");
    rdc(8'h20, "t2_rd");

    wr(8'h14, 4'hF, 32'h0, "t3_edge");
    wr(8'h0C, 4'hF, 32'h1, "t3_en");
    m_pins(m_in[0] | 32'h1, m_in[1]);
    @(posedge clk); #1;
    gpi = {m_in[1], m_in[0]};
`ifndef GPIO_DEBOUNCE_EN
    repeat (4) @(posedge clk);
    #1;
    chk("t3_irq_latency", 64'(irq), 64'd1);
`endif
    repeat (SETTLE) @(posedge clk);
    #1;
    chk_outs("t3_rise");
    rdc(8'h10, "t3_stat");
    wr(8'h10, 4'hF, 32'h1, "t3_w1c");
    chk("t3_irq_clr", 64'(irq), 64'd0);

`ifndef GPIO_DEBOUNCE_EN
    set_pins(m_in[0] | 32'h8, m_in[1]);
    set_pins(m_in[0] & ~32'h8, m_in[1]);
    rdc(8'h10, "t4_pre");
    m_write(8'h10, 4'hF, 32'h8);
    m_pins(m_in[0] | 32'h8, m_in[1]);
    @(posedge clk); #1;
    gpi = {m_in[1], m_in[0]};
    @(posedge clk);
    xfer(1, 8'h10, 4'hF, 32'h8, "t4_w1c");
    rdc(8'h10, "t4_stat");
`endif

    rdc(8'h40, "t5_rd");
    wr(8'h40, 4'hF, 32'hFFFF_FFFF, "t5_wr");
    for (int i = 0; i < 8; i++) rdc(8'(i * 4), "t5_ch0");
    chk_outs("t5");

`ifdef GPIO_DEBOUNCE_EN
    @(posedge clk); #1;
    gpi[2] = ~m_in[0][2];
    repeat (5) @(posedge clk);
    #1;
    gpi[2] = m_in[0][2];
    repeat (SETTLE) @(posedge clk);
    #1;
    rdc(8'h08, "t6_glitch_in");
    rdc(8'h10, "t6_glitch_stat");
    set_pins(m_in[0] | 32'h4, m_in[1]);
    rdc(8'h08, "t6_in");
    rdc(8'h10, "t6_stat");
`endif

    for (int it = 0; it < 80; it++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k < 5) wr(8'($urandom_range(0, 95)), 4'($urandom), $urandom, "rnd_wr");
      else if (k < 8) rdc(8'($urandom_range(0, 95)), "rnd_rd");
      else set_pins($urandom, $urandom);
      chk_outs("rnd");
    end
    for (int i = 0; i < 16; i++) rdc(8'(i * 4), "final_rd");

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
